// File: rtl/lcd_cmd_sequencer.sv
// Character-LCD 4-bit command sequencer: passes the init FSM's pin drive through until
// init_done, sends the fixed configuration bytes, then serves client byte writes.
module lcd_cmd_sequencer #(
    parameter int T_SETUP = 2,
    parameter int T_PULSE = 12,
    parameter int T_HOLD  = 1,
    parameter int T_GAP   = 50,
    parameter int T_CMD   = 2000,
    parameter int T_CLEAR = 82000,
    parameter int CNT_W   = 17
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       init_done,
    input  logic       I_LCD_E,
    input  logic [7:0] I_SF_D,
    input  logic       cmd_valid,
    input  logic       cmd_rs,
    input  logic [7:0] cmd_data,
    output logic       cmd_ready,
    output logic       cfg_done,
    output logic       busy,
    output logic       LCD_E,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic [7:0] SF_D
);

    typedef enum logic [3:0] {
        PASS,
        CFG_LOAD,
        SETUP_HI,
        PULSE_HI,
        HOLD_HI,
        GAP,
        SETUP_LO,
        PULSE_LO,
        HOLD_LO,
        WAIT,
        IDLE
    } state_t;

    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(T_PULSE - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(T_HOLD - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(T_GAP - 1);
    localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(T_CMD - 1);
    localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(T_CLEAR - 1);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       cfg_idx_q;
    logic             cfg_done_q;
    logic [7:0]       byte_q;
    logic             rs_q;

    logic             load_cfg;
    logic             load_cmd;
    logic             cfg_adv;
    logic             cfg_fin;
    logic [CNT_W-1:0] wait_last;
    logic [3:0]       nibble;

    function automatic logic [7:0] cfg_rom(input logic [1:0] idx);
        case (idx)
            2'd0:    return 8'h28;
            2'd1:    return 8'h06;
            2'd2:    return 8'h0C;
            default: return 8'h01;
        endcase
    endfunction

    // Clear Display (0x01) and Return Home (0x02/0x03) need the long execution wait.
    function automatic logic is_slow(input logic rs, input logic [7:0] b);
        return !rs && (b == 8'h01 || b == 8'h02 || b == 8'h03);
    endfunction

    assign wait_last = is_slow(rs_q, byte_q) ? CLEAR_LAST : CMD_LAST;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= PASS;
            cnt_q      <= '0;
            cfg_idx_q  <= 2'd0;
            cfg_done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q || state_q == PASS || state_q == IDLE)
                cnt_q <= '0;
            else
                cnt_q <= cnt_q + 1'b1;
            if (!init_done) begin
                cfg_idx_q  <= 2'd0;
                cfg_done_q <= 1'b0;
            end else begin
                if (cfg_adv)
                    cfg_idx_q <= cfg_idx_q + 2'd1;
                if (cfg_fin)
                    cfg_done_q <= 1'b1;
            end
        end
    end

    // The byte being shifted out carries no control meaning until loaded, so it is not reset.
    always_ff @(posedge clk) begin
        if (load_cfg) begin
            byte_q <= cfg_rom(cfg_idx_q);
            rs_q   <= 1'b0;
        end else if (load_cmd) begin
            byte_q <= cmd_data;
            rs_q   <= cmd_rs;
        end
    end

    always_comb begin
        state_d  = state_q;
        load_cfg = 1'b0;
        load_cmd = 1'b0;
        cfg_adv  = 1'b0;
        cfg_fin  = 1'b0;
        case (state_q)
            PASS: begin
                if (init_done)
                    state_d = CFG_LOAD;
            end
            CFG_LOAD: begin
                load_cfg = 1'b1;
                state_d  = SETUP_HI;
            end
            SETUP_HI: if (cnt_q == SETUP_LAST) state_d = PULSE_HI;
            PULSE_HI: if (cnt_q == PULSE_LAST) state_d = HOLD_HI;
            HOLD_HI:  if (cnt_q == HOLD_LAST)  state_d = GAP;
            GAP:      if (cnt_q == GAP_LAST)   state_d = SETUP_LO;
            SETUP_LO: if (cnt_q == SETUP_LAST) state_d = PULSE_LO;
            PULSE_LO: if (cnt_q == PULSE_LAST) state_d = HOLD_LO;
            HOLD_LO:  if (cnt_q == HOLD_LAST)  state_d = WAIT;
            WAIT: begin
                if (cnt_q == wait_last) begin
                    if (cfg_done_q) begin
                        state_d = IDLE;
                    end else if (cfg_idx_q == 2'd3) begin
                        cfg_fin = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cfg_adv = 1'b1;
                        state_d = CFG_LOAD;
                    end
                end
            end
            IDLE: begin
                if (cmd_valid) begin
                    load_cmd = 1'b1;
                    state_d  = SETUP_HI;
                end
            end
            default: state_d = PASS;
        endcase
        // Losing init_done abandons whatever is in flight and hands the pins back.
        if (!init_done) begin
            state_d  = PASS;
            load_cmd = 1'b0;
            cfg_adv  = 1'b0;
            cfg_fin  = 1'b0;
        end
    end

    always_comb begin
        nibble = byte_q[3:0];
        if (state_q == SETUP_HI || state_q == PULSE_HI || state_q == HOLD_HI || state_q == GAP)
            nibble = byte_q[7:4];
    end

    always_comb begin
        cmd_ready = (state_q == IDLE);
        busy      = (state_q != IDLE);
        cfg_done  = cfg_done_q;
        LCD_RW    = 1'b0;
        LCD_E     = 1'b0;
        LCD_RS    = rs_q;
        SF_D      = {4'h0, nibble};
        case (state_q)
            PASS: begin
                LCD_E  = I_LCD_E;
                SF_D   = I_SF_D;
                LCD_RS = 1'b0;
            end
            PULSE_HI, PULSE_LO: LCD_E = 1'b1;
            default: LCD_E = 1'b0;
        endcase
    end

endmodule
